// File: rtl/parity_checker_serial.sv
// ---------------------------------------------------------------------------
// parity_checker_serial
//
// Receive-side serial parity checker. A frame is DATA_W data bits (LSB first)
// followed by one parity bit, taken from a gated bit stream (in_valid). The
// completed frame is checked against odd or even parity, the recovered word
// is presented with a pass/fail flag, and failed frames are counted in a
// saturating error counter.
//
// Parameters
//   DATA_W    data bits per frame (>= 1)
//   CNT_W     width of the failed-frame counter
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   in_bit is valid this cycle
//   in_bit     serial bit: data bits LSB first, then the parity bit
//   odd        1 = odd parity, 0 = even; sampled with data bit 0 only
//   abort      synchronous frame discard (wins over in_valid)
//   busy       a frame is partially received
//   out_valid  one-cycle pulse: frame complete
//   out_data   last completed data word
//   check      1 = last completed frame passed parity
//   err_count  saturating count of failed frames
// ---------------------------------------------------------------------------
module parity_checker_serial #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_bit,
    input  logic              odd,
    input  logic              abort,
    output logic              busy,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              check,
    output logic [CNT_W-1:0]  err_count
);

    // Bit index width; a 1-bit frame still needs a (constant-zero) index.
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic               acc_q, acc_d;
    logic               mode_q, mode_d;
    logic [DATA_W-1:0]  shadow_q, shadow_d;

    logic               busy_d;
    logic               out_valid_d;
    logic [DATA_W-1:0]  out_data_d;
    logic               check_d;
    logic [CNT_W-1:0]   err_count_d;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Frame verdict: the XOR over data plus parity must be 1 for odd parity
    // and 0 for even parity.
    function automatic logic frame_pass(input logic acc, input logic par,
                                        input logic mode);
        logic total;
        total = acc ^ par;
        return mode ? total : ~total;
    endfunction

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mode_d      = mode_q;
        shadow_d    = shadow_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data;
        check_d     = check;
        err_count_d = err_count;

        if (abort) begin
            // Discard any partial frame; a coincident bit is dropped and the
            // previously presented results stay untouched.
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = 1'b0;
        end else if (in_valid) begin
            unique case (state_q)
                IDLE, DATA: begin
                    // In IDLE cnt_q and acc_q are already zero, so the first
                    // data bit shares the DATA path; only the parity mode is
                    // captured here.
                    if (state_q == IDLE) begin
                        mode_d = odd;
                    end
                    shadow_d[cnt_q] = in_bit;
                    acc_d           = acc_q ^ in_bit;
                    if (cnt_q == LAST_IDX) begin
                        state_d = PAR;
                        cnt_d   = '0;
                    end else begin
                        state_d = DATA;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
                PAR: begin
                    check_d     = frame_pass(acc_q, in_bit, mode_q);
                    out_data_d  = shadow_q;
                    out_valid_d = 1'b1;
                    if (!frame_pass(acc_q, in_bit, mode_q)) begin
                        err_count_d = sat_inc(err_count);
                    end
                    state_d = IDLE;
                    cnt_d   = '0;
                    acc_d   = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    acc_d   = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= 1'b0;
            mode_q    <= 1'b1;
            shadow_q  <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            check     <= 1'b0;
            err_count <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mode_q    <= mode_d;
            shadow_q  <= shadow_d;
            busy      <= busy_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            check     <= check_d;
            err_count <= err_count_d;
        end
    end

endmodule

// File: tb/tb_parity_checker_serial.sv
// ---------------------------------------------------------------------------
// tb_parity_checker_serial
//
// Three checker instances share one input stream: the default 8-bit frame
// with an 8-bit counter, an 8-bit frame with a 2-bit counter (saturation),
// and a 1-bit frame. A frame-level reference model (bit list, popcount)
// predicts every output of every instance each cycle; directed checks pin
// down the specific values of the named scenarios.
// ---------------------------------------------------------------------------
module tb_parity_checker_serial;

    logic clk;
    logic rst;
    logic in_valid;
    logic in_bit;
    logic odd;
    logic abort;

    logic       busy_a [3];
    logic       vld_a  [3];
    logic       chk_a  [3];
    logic [7:0] data0, data1;
    logic       data2;
    logic [7:0] err0;
    logic [1:0] err1;
    logic [3:0] err2;

    int n_cmp = 0;
    int n_bad = 0;

    parity_checker_serial #(.DATA_W(8), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .odd(odd), .abort(abort), .busy(busy_a[0]), .out_valid(vld_a[0]),
        .out_data(data0), .check(chk_a[0]), .err_count(err0)
    );

    parity_checker_serial #(.DATA_W(8), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .odd(odd), .abort(abort), .busy(busy_a[1]), .out_valid(vld_a[1]),
        .out_data(data1), .check(chk_a[1]), .err_count(err1)
    );

    parity_checker_serial #(.DATA_W(1), .CNT_W(4)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .odd(odd), .abort(abort), .busy(busy_a[2]), .out_valid(vld_a[2]),
        .out_data(data2), .check(chk_a[2]), .err_count(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, one slot per instance.
    int         dw   [3] = '{8, 8, 1};
    int         cmax [3] = '{255, 3, 15};
    int         m_n  [3];
    logic [7:0] m_sh [3];
    logic       m_mode [3];
    logic [7:0] m_data [3];
    logic       m_chk  [3];
    int         m_err  [3];
    logic       m_vld  [3];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_n[i]    = 0;
            m_sh[i]   = '0;
            m_mode[i] = 1'b1;
            m_data[i] = '0;
            m_chk[i]  = 1'b0;
            m_err[i]  = 0;
            m_vld[i]  = 1'b0;
        end
    endtask

    // One accepted-cycle step of the frame model, using the inputs the DUT
    // will sample at the coming edge.
    task automatic model_step();
        int  ones;
        bit  pass;
        for (int i = 0; i < 3; i++) begin
            m_vld[i] = 1'b0;
            if (abort) begin
                m_n[i] = 0;
            end else if (in_valid) begin
                if (m_n[i] == 0) m_mode[i] = odd;
                if (m_n[i] < dw[i]) begin
                    m_sh[i][m_n[i]] = in_bit;
                    m_n[i]++;
                end else begin
                    ones = $countones(m_sh[i]) + int'(in_bit);
                    pass = m_mode[i] ? (ones % 2 == 1) : (ones % 2 == 0);
                    m_data[i] = m_sh[i];
                    m_chk[i]  = pass;
                    if (!pass && m_err[i] < cmax[i]) m_err[i]++;
                    m_vld[i] = 1'b1;
                    m_n[i]   = 0;
                    m_sh[i]  = '0;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] gd [3];
        logic [31:0] ge [3];
        gd[0] = 32'(data0); gd[1] = 32'(data1); gd[2] = 32'(data2);
        ge[0] = 32'(err0);  ge[1] = 32'(err1);  ge[2] = 32'(err2);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s.i%0d.busy", tag, i), 32'(busy_a[i]), 32'(m_n[i] != 0));
            chk($sformatf("%s.i%0d.out_valid", tag, i), 32'(vld_a[i]), 32'(m_vld[i]));
            chk($sformatf("%s.i%0d.out_data", tag, i), gd[i], 32'(m_data[i]));
            chk($sformatf("%s.i%0d.check", tag, i), 32'(chk_a[i]), 32'(m_chk[i]));
            chk($sformatf("%s.i%0d.err_count", tag, i), ge[i], 32'(m_err[i]));
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all("cyc");
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        in_bit   = 1'($urandom);
        cycle();
    endtask

    task automatic send_bit(input logic b, input int maxgap);
        int gap;
        gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        repeat (gap) idle_cycle();
        in_valid = 1'b1;
        in_bit   = b;
        cycle();
        in_valid = 1'b0;
    endtask

    // Data bits LSB first, then parity; optionally scramble odd after bit 0.
    task automatic send_frame(input logic [7:0] d, input logic par,
                              input logic o, input int maxgap, input bit tog);
        odd = o;
        for (int j = 0; j < 8; j++) begin
            send_bit(d[j], maxgap);
            if (tog) odd = 1'($urandom);
        end
        send_bit(par, maxgap);
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge.
    task automatic apply_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        abort    = 1'b0;
        #2;
        model_reset();
        chk("rst_async.busy", 32'(busy_a[0]), 32'd0);
        chk("rst_async.out_valid", 32'(vld_a[0]), 32'd0);
        chk("rst_async.out_data", 32'(data0), 32'd0);
        chk("rst_async.check", 32'(chk_a[0]), 32'd0);
        chk("rst_async.err_count", 32'(err0), 32'd0);
        check_all("rst");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        rst = 1'b0;
    endtask

    logic [1:0] sat_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        odd      = 1'b1;
        abort    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;
        idle_cycle();

        // 0xA5, odd parity, correct parity bit.
        send_frame(8'hA5, 1'b1, 1'b1, 0, 0);
        chk("a5.out_valid", 32'(vld_a[0]), 32'd1);
        chk("a5.out_data", 32'(data0), 32'hA5);
        chk("a5.check", 32'(chk_a[0]), 32'd1);
        chk("a5.err_count", 32'(err0), 32'd0);
        idle_cycle();
        chk("a5.pulse_end", 32'(vld_a[0]), 32'd0);

        // Same frame with wrong parity, then 0x01 back-to-back.
        send_frame(8'hA5, 1'b0, 1'b1, 0, 0);
        chk("a5bad.check", 32'(chk_a[0]), 32'd0);
        chk("a5bad.err_count", 32'(err0), 32'd1);
        send_frame(8'h01, 1'b0, 1'b1, 0, 0);
        chk("x01.out_data", 32'(data0), 32'h01);
        chk("x01.check", 32'(chk_a[0]), 32'd1);
        chk("x01.err_count", 32'(err0), 32'd1);

        // Even parity with gaps and odd toggling mid-frame.
        send_frame(8'h07, 1'b1, 1'b0, 3, 1);
        chk("x07.out_data", 32'(data0), 32'h07);
        chk("x07.check", 32'(chk_a[0]), 32'd1);

        // Abort after 5 bits of 0xFF, then a clean 0x3C frame.
        odd = 1'b1;
        for (int j = 0; j < 5; j++) send_bit(1'b1, 1);
        abort = 1'b1;
        idle_cycle();
        abort = 1'b0;
        chk("abort5.busy", 32'(busy_a[0]), 32'd0);
        chk("abort5.out_data", 32'(data0), 32'h07);
        send_frame(8'h3C, 1'b1, 1'b1, 1, 0);
        chk("x3c.out_valid", 32'(vld_a[0]), 32'd1);
        chk("x3c.out_data", 32'(data0), 32'h3C);
        chk("x3c.check", 32'(chk_a[0]), 32'd1);

        // Abort coincident with the parity bit drops the frame.
        for (int j = 0; j < 8; j++) send_bit(1'b0, 0);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        abort    = 1'b1;
        cycle();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abortpar.out_valid", 32'(vld_a[0]), 32'd0);
        chk("abortpar.busy", 32'(busy_a[0]), 32'd0);
        chk("abortpar.out_data", 32'(data0), 32'h3C);
        idle_cycle();

        // Saturation of a 2-bit counter over five failing frames.
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            send_frame(8'h00, 1'b0, 1'b1, 0, 0);
            chk($sformatf("sat%0d.err_count", k), 32'(err1), 32'(sat_seq[k]));
            chk($sformatf("sat%0d.err8", k), 32'(err0), 32'(k + 1));
        end

        // Reset mid-frame, then a fresh 9-bit frame.
        send_frame(8'h96, 1'b0, 1'b1, 0, 0);
        for (int j = 0; j < 4; j++) send_bit(1'b1, 0);
        apply_reset();
        send_frame(8'h5A, 1'b1, 1'b1, 0, 0);
        chk("post_rst.out_valid", 32'(vld_a[0]), 32'd1);
        chk("post_rst.out_data", 32'(data0), 32'h5A);
        chk("post_rst.check", 32'(chk_a[0]), 32'd1);

        // 1-bit frame: bit 1, parity 0, odd parity.
        apply_reset();
        odd = 1'b1;
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        chk("w1.out_valid", 32'(vld_a[2]), 32'd1);
        chk("w1.out_data", 32'(data2), 32'd1);
        chk("w1.check", 32'(chk_a[2]), 32'd1);
        abort = 1'b1;
        idle_cycle();
        abort = 1'b0;

        // Random frames, then fully random traffic with occasional aborts.
        for (int k = 0; k < 20; k++) begin
            send_frame(8'($urandom), 1'($urandom), 1'($urandom), 2, 1);
        end
        for (int k = 0; k < 600; k++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_bit   = 1'($urandom);
            odd      = 1'($urandom);
            abort    = ($urandom_range(0, 24) == 0);
            cycle();
        end
        abort    = 1'b0;
        in_valid = 1'b0;
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
